// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   DATA_W / ADDR_W : data word and word-address widths
//   CNT_W           : width of the latency countdown (LATENCY up to 15)
//   dmem_state_e    : FSM state encoding
//   byte_swap()     : byte reversal used when DMEM_BYTESWAP_EN is defined
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } dmem_state_e;

  // Self-inverse: the same function converts to and from storage order.
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/dmem_latency_ctr.sv
// Access latency countdown for dmem_responder.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset, clears the count
//   load     : load load_val (takes priority over dec)
//   load_val : initial countdown value
//   dec      : decrement by one (saturates at zero)
//   expire   : count is 1, so the next decrement finishes the wait
module dmem_latency_ctr
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed multi-cycle access latency.
// An access is accepted in StIdle, waits in StBusy, and completes on the edge
// entering StDone (write committed or read data loaded). StDone lasts one cycle
// and ignores mem_cen, so back-to-back accesses repeat every LATENCY+1 cycles.
// Out-of-range addresses (>= DEPTH) drop writes and read back zero.
//
// Parameters: LATENCY (1..15) stall cycles per access, DEPTH words stored.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset (clears state, rdata, storage)
//   mem_cen   : access request
//   mem_wen   : 1 = write, 0 = read
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_rdata : last read result
//   mem_stall : access not yet complete
// Build option: define DMEM_BYTESWAP_EN to keep words byte-reversed in storage;
// port-visible behaviour is the same either way.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_cen,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall
);

  localparam int unsigned      IdxW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LoadVal     = CNT_W'(LATENCY - 1);
  localparam bit               SingleCycle = (LATENCY == 1);

  dmem_state_e       state_q, state_d;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              cap_en, ctr_load, ctr_dec, ctr_expire, commit;
  logic              acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic [IdxW-1:0]   acc_idx;
  logic [DATA_W-1:0] stored_wdata, loaded_rdata;

  dmem_latency_ctr u_latency_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (LoadVal),
    .dec      (ctr_dec),
    .expire   (ctr_expire)
  );

  // With LATENCY=1 the commit edge is also the capture edge, so the live
  // inputs are used; otherwise only the captured request is.
  always_comb begin
    if (state_q == StIdle) begin
      acc_wen   = mem_wen;
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    in_range = (acc_addr < ADDR_W'(DEPTH));
    acc_idx  = acc_addr[IdxW-1:0];
  end

`ifdef DMEM_BYTESWAP_EN
  assign stored_wdata = byte_swap(acc_wdata);
  assign loaded_rdata = byte_swap(mem_q[acc_idx]);
`else
  assign stored_wdata = acc_wdata;
  assign loaded_rdata = mem_q[acc_idx];
`endif

  always_comb begin
    state_d   = state_q;
    cap_en    = 1'b0;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    commit    = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_stall = mem_cen;
        if (mem_cen) begin
          cap_en   = 1'b1;
          ctr_load = 1'b1;
          if (SingleCycle) begin
            state_d = StDone;
            commit  = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // Held low during reset so an aborted access never looks pending.
        mem_stall = rst;
        ctr_dec   = 1'b1;
        if (ctr_expire) begin
          state_d = StDone;
          commit  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        wen_q   <= mem_wen;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (commit && !acc_wen) begin
        rdata_q <= in_range ? loaded_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && acc_wen && in_range) begin
      mem_q[acc_idx] <= stored_wdata;
    end
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=4 and one with LATENCY=1,
// checked against an array model of memory contents and the last read result.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen   [2];
  logic        wen   [2];
  logic [29:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(4), .DEPTH(256)) u_dut_l4 (
    .clk       (clk),
    .rst       (rst),
    .mem_cen   (cen[0]),
    .mem_wen   (wen[0]),
    .mem_addr  (addr[0]),
    .mem_wdata (wdata[0]),
    .mem_rdata (rdata[0]),
    .mem_stall (stall[0])
  );

  dmem_responder #(.LATENCY(1), .DEPTH(256)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .mem_cen   (cen[1]),
    .mem_wen   (wen[1]),
    .mem_addr  (addr[1]),
    .mem_wdata (wdata[1]),
    .mem_rdata (rdata[1]),
    .mem_stall (stall[1])
  );

  int unsigned lat [2] = '{4, 1};
  logic [31:0] model_mem   [2][256];
  logic [31:0] model_rdata [2];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_done [2] = '{0, 0};

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) model_mem[d][i] = '0;
      model_rdata[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) cen[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  // Starts in an idle cycle (posedge+1); returns at posedge+1 of the idle
  // cycle after completion with cen dropped (caller may re-raise at once).
  task automatic access(input int d, input bit w, input logic [29:0] a,
                        input logic [31:0] wd, input bit scramble, input bit chk_period);
    int sc;
    bit seen_done;
    cen[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    sc = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (!stall[d]) begin
        seen_done = 1'b1;
        break;
      end
      sc++;
      @(posedge clk);
      #1;
      if (scramble) begin
        wen[d]   = 1'($urandom);
        addr[d]  = 30'($urandom_range(0, 299));
        wdata[d] = $urandom;
      end
    end
    check_eq("done_reached", 32'(seen_done), 32'd1);
    check_eq("stall_cycles", 32'(sc), 32'(lat[d]));
    if (w) begin
      if (a < 256) model_mem[d][a[7:0]] = wd;
    end else begin
      model_rdata[d] = (a < 256) ? model_mem[d][a[7:0]] : 32'h0;
    end
    check_eq(w ? "rdata_after_write" : "rdata_after_read", rdata[d], model_rdata[d]);
    if (chk_period) check_eq("period", 32'(cyc - last_done[d]), 32'(lat[d] + 1));
    last_done[d] = cyc;
    @(posedge clk);
    #1 cen[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      cen[d] = 1'b0; wen[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    do_reset();

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_rdata", rdata[d], 32'h0);
      check_eq("reset_stall", 32'(stall[d]), 32'h0);
    end
    @(posedge clk);
    #1;

    // Read after reset, then write/read pair with one idle gap
    access(0, 1'b0, 30'd5, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, 30'd128, 32'h1234_5678, 1'b0, 1'b0);
    access(0, 1'b0, 30'd128, 32'h0, 1'b0, 1'b1);
    check_eq("rd128_literal", rdata[0], 32'h1234_5678);

    // Out-of-range write dropped, read returns zero
    access(0, 1'b1, 30'd300, 32'hDEAD_BEEF, 1'b0, 1'b1);
    access(0, 1'b0, 30'd300, 32'h0, 1'b0, 1'b1);
    check_eq("rd300_literal", rdata[0], 32'h0);

    // Reset in the second busy cycle of a write aborts it
    cen[0] = 1'b1; wen[0] = 1'b1; addr[0] = 30'd10; wdata[0] = 32'hAAAA_5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("stall_in_reset", 32'(stall[0]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1; cen[0] = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("post_reset_stall", 32'(stall[0]), 32'h0);
    check_eq("post_reset_rdata", rdata[0], 32'h0);
    @(posedge clk);
    #1;
    access(0, 1'b0, 30'd10, 32'h0, 1'b0, 1'b0);

    // Inputs changing while busy are ignored
    access(0, 1'b1, 30'd7, 32'h0000_0007, 1'b1, 1'b0);
    access(0, 1'b0, 30'd7, 32'h0, 1'b0, 1'b1);
    check_eq("rd7_literal", rdata[0], 32'h7);
    access(0, 1'b0, 30'd6, 32'h0, 1'b0, 1'b1);
    access(0, 1'b0, 30'd8, 32'h0, 1'b0, 1'b1);

    // LATENCY=1: back-to-back writes then reads
    for (int i = 0; i < 8; i++)
      access(1, 1'b1, 30'(128 + i), 32'hC0DE_0000 + 32'(i * 7 + 1), 1'b0, i != 0);
    for (int i = 0; i < 8; i++)
      access(1, 1'b0, 30'(128 + i), 32'h0, 1'b0, 1'b1);
    check_eq("l1_rd135_literal", rdata[1], 32'hC0DE_0032);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      bit prev_b2b;
      prev_b2b = 1'b0;
      for (int n = 0; n < 80; n++) begin
        logic [29:0] ra;
        bit rw, rs, b2b;
        ra  = ($urandom_range(0, 3) == 0) ? 30'($urandom_range(256, 400))
                                          : 30'($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) ra = 30'($urandom_range(0, 15));
        rw  = 1'($urandom);
        rs  = 1'($urandom);
        b2b = 1'($urandom);
        access(d, rw, ra, $urandom, rs, prev_b2b);
        if (!b2b) repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        prev_b2b = b2b;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles mem_stall is held per access; legal range 1..15.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_cen  input  1  access request from CPU side.
REQ-006 SHALL have port mem_wen  input  1  1 = write, 0 = read; valid with mem_cen.
REQ-007 SHALL have port mem_addr  input  30  word address.
REQ-008 SHALL have port mem_wdata  input  32  write data, CPU little-endian byte order.
REQ-009 SHALL have port mem_rdata  output  32  read data, CPU little-endian byte order.
REQ-010 SHALL have port mem_stall  output  1  request not yet complete; CPU holds request while high.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 IDLE with mem_cen=1 SHALL capture addr/wen/wdata at the edge, load countdown = LATENCY-1, go to BUSY (LATENCY=1: go directly to DONE).
REQ-013 mem_stall SHALL be combinational: 1 when (IDLE and mem_cen) or BUSY, else 0; high for exactly LATENCY cycles per access.
REQ-014 BUSY SHALL decrement countdown each cycle; edge with countdown=1 SHALL enter DONE.
REQ-015 Edge entering DONE SHALL commit a captured write to storage, or load mem_rdata from storage for a captured read.
REQ-016 DONE SHALL last one cycle, mem_stall=0, and SHALL ignore mem_cen (belongs to completed access); next state IDLE.
REQ-017 Inputs changing during BUSY SHALL be ignored; only captured values used.
REQ-018 mem_rdata SHALL hold last read result until next read completes; writes SHALL NOT alter mem_rdata.
REQ-019 Address >= DEPTH SHALL complete with normal timing; write dropped, read returns 32'h0000_0000.
REQ-020 Back-to-back accesses SHALL have one IDLE cycle between DONE and next acceptance; period LATENCY+1 cycles.

Reset
REQ-021 rst=0 at a rising edge SHALL force IDLE, countdown 0, mem_rdata 0, all storage words 0.
REQ-022 Reset during BUSY SHALL abort the access with no storage write; mem_stall SHALL read 0 while rst=0 and state is not IDLE.

Configuration
REQ-023 Macro DMEM_BYTESWAP_EN defined: storage SHALL hold readable order {d[7:0],d[15:8],d[23:16],d[31:24]} applied on write and reversed on read.
REQ-024 Macro DMEM_BYTESWAP_EN undefined: storage SHALL hold data exactly as on mem_wdata; port-visible behaviour identical either way.

Structure
REQ-025 Shared package dmem_pkg SHALL hold FSM state encoding (2 bits), DATA_W=32, ADDR_W=30, and byte-swap function.
REQ-026 Sub-module dmem_latency_ctr SHALL hold the countdown (load, decrement, expire flag); storage array and FSM stay in dmem_responder.

Verification
REQ-027 Reset then read addr 5 -> mem_stall high 4 cycles, DONE cycle mem_rdata=0.
REQ-028 Write 32'h1234_5678 to addr 128, then read addr 128 -> mem_rdata=32'h1234_5678, stall 4 cycles each, one IDLE gap.
REQ-029 Write addr 300 data 32'hDEAD_BEEF, read addr 300 -> mem_rdata=0, timing unchanged.
REQ-030 Start write 32'hAAAA_5555 addr 10, assert rst in 2nd BUSY cycle, release, read addr 10 -> 0.
REQ-031 LATENCY=1: eight back-to-back writes addr 128..135 then reads -> stall 1 cycle each, data matches, period 2 cycles.
REQ-032 Change mem_addr/mem_wdata every BUSY cycle during write to addr 7 value 32'h0000_0007 -> only addr 7 holds 7; DMEM_BYTESWAP_EN on/off gives identical rdata.
